// File: rtl/alu_op_sequencer_if.sv
// Request/response channel between a requester and the ALU op sequencer.
interface alu_op_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [2:0]       req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_r;
  logic [3:0]       rsp_flags;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_r, rsp_flags
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_r, rsp_flags
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequencer that registers operands onto a combinational ALU, waits a fixed
// settle time, captures the result/flags and returns them over a handshake.
module alu_op_sequencer #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  alu_op_sequencer_if.slave bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_c_out,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic [2:0]       status,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_RESP
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] rsp_r_q, rsp_r_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;
  logic [2:0]       status_q, status_d;
  logic [15:0]      op_count_q, op_count_d;
  logic             op_legal;

  // Decode the opcodes the ALU actually implements.
  always_comb begin
    op_legal = bus.req_op inside {3'b000, 3'b001, 3'b010, 3'b110};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: illegal ops skip the settle wait and answer at once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.req_valid) state_d = op_legal ? S_SETTLE : S_RESP;
      S_SETTLE: if (cnt_q == '0)   state_d = S_RESP;
      S_RESP:   if (bus.rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs: handshake flags follow the state, data comes from registers.
  always_comb begin
    bus.req_ready = (state_q == S_IDLE);
    bus.rsp_valid = (state_q == S_RESP);
    bus.rsp_r     = rsp_r_q;
    bus.rsp_flags = rsp_flags_q;
    alu_a         = alu_a_q;
    alu_b         = alu_b_q;
    alu_op        = alu_op_q;
    status        = status_q;
    op_count      = op_count_q;
  end

  // Datapath next values; ALU drive only changes on a legal accept so the
  // ALU inputs stay put while the result is being captured.
  always_comb begin
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_r_d     = rsp_r_q;
    rsp_flags_d = rsp_flags_q;
    status_d    = status_q;
    op_count_d  = op_count_q;
    if (state_q == S_IDLE && bus.req_valid) begin
      if (op_legal) begin
        alu_a_d  = bus.req_a;
        alu_b_d  = bus.req_b;
        alu_op_d = bus.req_op;
        cnt_d    = CNT_LOAD;
      end else begin
        rsp_r_d     = '0;
        rsp_flags_d = 4'b1000;
      end
    end
    if (state_q == S_SETTLE) begin
      if (cnt_q == '0) begin
        rsp_r_d     = alu_r;
        rsp_flags_d = {1'b0, alu_c_out, alu_overflow, alu_zero};
        status_d    = {alu_c_out, alu_overflow, alu_zero};
        op_count_d  = op_count_q + 16'd1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_r_q     <= '0;
      rsp_flags_q <= '0;
      status_q    <= '0;
      op_count_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_r_q     <= rsp_r_d;
      rsp_flags_q <= rsp_flags_d;
      status_q    <= status_d;
      op_count_q  <= op_count_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU attached.
module tb_alu_op_sequencer;
  localparam int unsigned W  = 16;
  localparam int unsigned SC = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.WIDTH(W)) bus ();

  logic [W-1:0] alu_a, alu_b, alu_r;
  logic [2:0]   alu_op, status;
  logic         alu_c_out, alu_overflow, alu_zero;
  logic [15:0]  op_count;
  logic [16:0]  alu_s;

  alu_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_r(alu_r), .alu_c_out(alu_c_out), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .status(status), .op_count(op_count)
  );

  // Combinational ALU stand-in (ripple-style add/sub with sign-bit overflow).
  always_comb begin
    alu_s        = '0;
    alu_r        = '0;
    alu_c_out    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op)
      3'b000: alu_r = alu_a & alu_b;
      3'b001: alu_r = alu_a | alu_b;
      3'b010: begin
        alu_s        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_r        = alu_s[15:0];
        alu_c_out    = alu_s[16];
        alu_overflow = (alu_a[15] == alu_b[15]) && (alu_s[15] != alu_a[15]);
      end
      3'b110: begin
        alu_s        = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
        alu_r        = alu_s[15:0];
        alu_c_out    = alu_s[16];
        alu_overflow = (alu_a[15] != alu_b[15]) && (alu_s[15] != alu_a[15]);
      end
      default: alu_r = '0;
    endcase
    alu_zero = (alu_r == '0);
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Reference: {illegal, c, v, z, r} from plain integer arithmetic.
  function automatic logic [19:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                         input logic [2:0] op);
    int ua, ub, sa, sb, res;
    logic [15:0] r;
    logic il, c, v, z;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    il = 1'b0; c = 1'b0; v = 1'b0; r = '0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin
        res = ua + ub; r = 16'(res); c = (res > 65535);
        v = (sa + sb > 32767) || (sa + sb < -32768);
      end
      3'b110: begin
        res = ua - ub; r = 16'(res); c = (ua >= ub);
        v = (sa - sb > 32767) || (sa - sb < -32768);
      end
      default: il = 1'b1;
    endcase
    z = !il && (r == 16'h0000);
    return {il, c, v, z, r};
  endfunction

  // One full transaction; returns response data and accept-to-valid edge count.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                       input int hold, output logic [15:0] r, output logic [3:0] f,
                       output int lat);
    int guard;
    @(negedge clk);
    bus.req_a = a; bus.req_b = b; bus.req_op = op; bus.req_valid = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) timeout("accept");
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    if (lat >= 50) timeout("rsp_valid");
    r = bus.rsp_r;
    f = bus.rsp_flags;
    repeat (hold) @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_alu_a"},     32'(alu_a), 32'd0);
    chk({tag, "_alu_b"},     32'(alu_b), 32'd0);
    chk({tag, "_alu_op"},    32'(alu_op), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_r"},     32'(bus.rsp_r), 32'd0);
    chk({tag, "_rsp_flags"}, 32'(bus.rsp_flags), 32'd0);
    chk({tag, "_status"},    32'(status), 32'd0);
    chk({tag, "_op_count"},  32'(op_count), 32'd0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [15:0] exp_r;
    logic [3:0]  exp_f;
    int          exp_lat;
  } vec_t;

  vec_t        vecs[9];
  logic [15:0] r, pa, pb;
  logic [3:0]  f;
  logic [2:0]  exp_status, pop, ps;
  logic [15:0] exp_count, pc;
  logic [19:0] e;
  int          lat, guard;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'd1,     16'd2,     3'b010, 16'd3,     4'b0000, 2};
    vecs[1] = '{16'd30000, 16'd30000, 3'b010, 16'hEA60,  4'b0010, 2};
    vecs[2] = '{16'h8AD0,  16'h8AD0,  3'b010, 16'h15A0,  4'b0110, 2};
    vecs[3] = '{16'hFFFF,  16'h0000,  3'b000, 16'h0000,  4'b0001, 2};
    vecs[4] = '{16'd20000, 16'd13000, 3'b110, 16'd7000,  4'b0100, 2};
    vecs[5] = '{16'h00F0,  16'h0F00,  3'b001, 16'h0FF0,  4'b0000, 2};
    vecs[6] = '{16'd5,     16'd5,     3'b110, 16'h0000,  4'b0101, 2};
    vecs[7] = '{16'h8000,  16'h0001,  3'b110, 16'h7FFF,  4'b0110, 2};
    vecs[8] = '{16'd3,     16'd4,     3'b011, 16'h0000,  4'b1000, 0};

    bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
    bus.rsp_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_vals("reset");
    exp_status = '0;
    exp_count  = '0;

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].op, 0, r, f, lat);
      if (!vecs[i].exp_f[3]) begin
        exp_status = vecs[i].exp_f[2:0];
        exp_count  = exp_count + 16'd1;
      end
      chk($sformatf("vec%0d_r", i),        32'(r), 32'(vecs[i].exp_r));
      chk($sformatf("vec%0d_flags", i),    32'(f), 32'(vecs[i].exp_f));
      chk($sformatf("vec%0d_lat", i),      32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_status", i),   32'(status), 32'(exp_status));
      chk($sformatf("vec%0d_op_count", i), 32'(op_count), 32'(exp_count));
    end

    // Illegal op leaves ALU drive, status and counter untouched.
    pa = alu_a; pb = alu_b; pop = alu_op; ps = status; pc = op_count;
    do_op(16'h1234, 16'h5678, 3'b111, 2, r, f, lat);
    chk("illegal_r", 32'(r), 32'd0);
    chk("illegal_flags", 32'(f), 32'b1000);
    chk("illegal_lat", 32'(lat), 32'd0);
    chk("illegal_alu_a", 32'(alu_a), 32'(pa));
    chk("illegal_alu_b", 32'(alu_b), 32'(pb));
    chk("illegal_alu_op", 32'(alu_op), 32'(pop));
    chk("illegal_status", 32'(status), 32'(ps));
    chk("illegal_op_count", 32'(op_count), 32'(pc));

    // Backpressure with a second request waiting.
    @(negedge clk);
    bus.req_a = 16'h0010; bus.req_b = 16'h0020; bus.req_op = 3'b010; bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_a = 16'h0100; bus.req_b = 16'h0001; bus.req_op = 3'b110;
    guard = 0;
    while (!bus.rsp_valid && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) timeout("bp_rsp_valid");
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("bp%0d_rsp_r", i),     32'(bus.rsp_r), 32'h30);
      chk($sformatf("bp%0d_flags", i),     32'(bus.rsp_flags), 32'd0);
      chk($sformatf("bp%0d_req_ready", i), 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("bp_idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("bp_idle_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("bp_second_accepted", 32'(bus.req_ready), 32'd0);
    guard = 0;
    while (!bus.rsp_valid && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) timeout("bp2_rsp_valid");
    chk("bp_second_lat", 32'(guard), 32'(SC));
    chk("bp_second_r", 32'(bus.rsp_r), 32'h00FF);
    chk("bp_second_flags", 32'(bus.rsp_flags), 32'b0100);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    exp_count  = exp_count + 16'd2;
    exp_status = 3'b100;
    chk("bp_status", 32'(status), 32'(exp_status));
    chk("bp_op_count", 32'(op_count), 32'(exp_count));

    // Randomized ops with random response backpressure.
    for (int i = 0; i < 150; i++) begin
      logic [15:0] ra, rb;
      logic [2:0]  rop;
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rop = 3'($urandom_range(0, 7));
      do_op(ra, rb, rop, int'($urandom_range(0, 3)), r, f, lat);
      e = ref_op(ra, rb, rop);
      if (!e[19]) begin
        exp_status = e[18:16];
        exp_count  = exp_count + 16'd1;
      end
      chk($sformatf("rnd%0d_r", i),        32'(r), 32'(e[15:0]));
      chk($sformatf("rnd%0d_flags", i),    32'(f), 32'(e[19:16]));
      chk($sformatf("rnd%0d_lat", i),      32'(lat), e[19] ? 32'd0 : 32'(SC));
      chk($sformatf("rnd%0d_status", i),   32'(status), 32'(exp_status));
      chk($sformatf("rnd%0d_op_count", i), 32'(op_count), 32'(exp_count));
    end

    // Reset one cycle after accepting a legal op: nothing comes back.
    @(negedge clk);
    bus.req_a = 16'd8; bus.req_b = 16'd4; bus.req_op = 3'b110; bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_vals("midreset");
    repeat (6) @(negedge clk);
    chk("midreset_no_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("midreset_op_count", 32'(op_count), 32'd0);

    // Counter wrap from 0xFFFF.
    @(negedge clk);
    force dut.op_count_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.op_count_q;
    chk("wrap_preload", 32'(op_count), 32'hFFFF);
    do_op(16'd1, 16'd1, 3'b010, 0, r, f, lat);
    chk("wrap_r", 32'(r), 32'd2);
    chk("wrap_op_count", 32'(op_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Sequential front-end that drives the 16-bit combinational CLA ALU (ports a, b, op; results r, c_out, overflow, zero). It accepts operation requests over a valid/ready handshake and registers the operands and opcode onto the ALU inputs. It waits a fixed settle time, then captures the result and flags, returns them over a valid/ready response channel, and maintains a processor-visible status register and an operation counter.

Parameters:
WIDTH, 16, operand/result width; must match the ALU.
SETTLE_CYCLES, 2, cycles between driving the ALU inputs and capturing its outputs; legal range 1..15.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_a  in  WIDTH  operand a
req_b  in  WIDTH  operand b
req_op  in  3  opcode: 000 and, 001 or, 010 add, 110 sub
alu_a  out  WIDTH  registered drive to ALU a
alu_b  out  WIDTH  registered drive to ALU b
alu_op  out  3  registered drive to ALU op
alu_r  in  WIDTH  ALU result
alu_c_out  in  1  ALU carry out
alu_overflow  in  1  ALU signed overflow
alu_zero  in  1  ALU zero flag
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts the response
rsp_r  out  WIDTH  captured result
rsp_flags  out  4  {illegal, c_out, overflow, zero}
status  out  3  {c, v, z} from the last legal completed operation
op_count  out  16  count of completed legal operations

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high.
- On reset:
  - State goes to IDLE; req_ready=1 after the reset edge.
  - alu_a=0, alu_b=0, alu_op=000.
  - rsp_valid=0, rsp_r=0, rsp_flags=0, status=0, op_count=0.
- Reset dominates every other input, including mid-operation. Any in-flight request and any pending response are discarded.
- States: IDLE, SETTLE, RESP.
- IDLE:
  - req_ready=1.
  - On the accept edge (req_valid & req_ready):
    - Legal op: alu_a/alu_b/alu_op take req_a/req_b/req_op; the settle counter loads SETTLE_CYCLES-1; go to SETTLE.
    - Illegal op (011, 100, 101, 111): the alu_* registers are unchanged. rsp_r=0, rsp_flags=4'b1000, rsp_valid=1; go to RESP. status and op_count are unchanged.
- SETTLE:
  - req_ready=0; the counter decrements each cycle.
  - On the edge where the counter is 0:
    - rsp_r=alu_r; rsp_flags={0, alu_c_out, alu_overflow, alu_zero}.
    - status={alu_c_out, alu_overflow, alu_zero}.
    - op_count increments, wrapping 0xFFFF to 0x0000.
    - rsp_valid=1; go to RESP.
- Latency:
  - Legal op: rsp_valid rises exactly SETTLE_CYCLES edges after the accept edge.
  - Illegal op: rsp_valid rises on the accept edge itself (visible one cycle later).
- RESP:
  - req_ready=0. rsp_valid, rsp_r and rsp_flags hold stable until rsp_valid & rsp_ready.
  - On that edge: rsp_valid=0; go to IDLE.
  - A new request is accepted no earlier than the following cycle, so back-to-back throughput is one operation per SETTLE_CYCLES+2 cycles.
- alu_* outputs hold their last values outside SETTLE, so the ALU inputs never glitch during capture.
- Flags are passed through from the ALU, not recomputed.
- req_* are ignored whenever req_ready=0.

Test Plan:
- Reset, then add: a=1, b=2, op=010 → rsp_valid exactly 2 cycles after accept; rsp_r=3, rsp_flags=0000, status=000, op_count=1.
- Overflow: a=30000, b=30000, op=010 → rsp_r=0xEA60, rsp_flags=0010. Then a=-30000, b=-30000, op=010 → rsp_r=0x15A0, rsp_flags=0110, status=110.
- Zero/sub: a=0xFFFF, b=0, op=000 → rsp_r=0, rsp_flags=0001. Then a=20000, b=13000, op=110 → rsp_r=7000, zero=0.
- Illegal op: op=011 → rsp_valid one cycle after accept, rsp_flags=1000, rsp_r=0; status, op_count and alu_* unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid → response stable, req_ready=0, a second req_valid is not accepted. Raise rsp_ready → IDLE next cycle, the second request is accepted the cycle after.
- Reset mid-SETTLE: assert reset one cycle after accepting a=8, b=4, op=110 → no response produced; all outputs return to reset values; op_count stays 0. Also run 65536 legal ops (or force op_count=0xFFFF) → op_count wraps to 0.
